// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver with a PicoBlaze read port.
// Conditions the raw PS/2 pins, deserialises device-to-host frames, and keeps
// the latest and previous scan codes together with ready/overrun/error flags.
module ps2_keyboard_rx #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 200000,
    parameter logic [7:0]  KEY_PORT    = 8'h0F,
    parameter logic [7:0]  STATUS_PORT = 8'h10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    input  logic       READ_STROBE,
    input  logic [7:0] PORT_ID,
    output logic [7:0] IN_PORT,
    output logic [7:0] TecladoREG,
    output logic [7:0] TecladoREG_ANTERIOR,
    output logic       KEY_READY,
    output logic       FRAME_ERR
);

    localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TmoW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } state_e;

    // Input synchronisers
    logic             ps2_clk_meta_q;
    logic             ps2_clk_sync_q;
    logic             ps2_data_meta_q;
    logic             ps2_data_sync_q;

    // Clock glitch filter
    logic             filt_q;
    logic             filt_d;
    logic             filt_prev_q;
    logic [FiltW-1:0] filt_cnt_q;
    logic [FiltW-1:0] filt_cnt_d;
    logic             fe;

    // Frame deserialiser
    state_e           state_q;
    state_e           state_d;
    logic [2:0]       bit_cnt_q;
    logic [2:0]       bit_cnt_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic             parity_q;
    logic             parity_d;
    logic [TmoW-1:0]  tmo_q;
    logic [TmoW-1:0]  tmo_d;
    logic             commit_q;
    logic             commit_d;
    logic             err_q;
    logic             err_d;

    // Host-visible registers
    logic [7:0]       key_q;
    logic [7:0]       key_d;
    logic [7:0]       prev_q;
    logic [7:0]       prev_d;
    logic [7:0]       in_port_q;
    logic [7:0]       in_port_d;
    logic             key_ready_q;
    logic             key_ready_d;
    logic             overrun_q;
    logic             overrun_d;
    logic             frame_err_q;
    logic             frame_err_d;
    logic             rd_key;
    logic             rd_status;

    // Two-flop synchronisers; both lines idle high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ps2_clk_meta_q  <= 1'b1;
            ps2_clk_sync_q  <= 1'b1;
            ps2_data_meta_q <= 1'b1;
            ps2_data_sync_q <= 1'b1;
        end else begin
            ps2_clk_meta_q  <= PS2_CLK;
            ps2_clk_sync_q  <= ps2_clk_meta_q;
            ps2_data_meta_q <= PS2_DATA;
            ps2_data_sync_q <= ps2_data_meta_q;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive samples at the new level.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (ps2_clk_sync_q != filt_q) begin
            if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
                filt_d = ps2_clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FiltW'(1);
            end
        end
    end

    // Filter state and previous filtered level for edge detection.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            filt_cnt_q  <= filt_cnt_d;
        end
    end

    assign fe = filt_prev_q & ~filt_q;

    // Frame FSM next state, shift register and inactivity timeout.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tmo_d     = tmo_q;
        commit_d  = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                tmo_d = '0;
                // A high bit on an idle FE is not a start bit; ignore it.
                if (fe && !ps2_data_sync_q) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (fe) begin
                    shift_d   = {ps2_data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (fe) begin
                    parity_d = ps2_data_sync_q;
                    state_d  = StStop;
                end
            end
            StStop: begin
                if (fe) begin
                    state_d = StIdle;
                    // Odd parity: data bits plus parity must XOR to one.
                    if (ps2_data_sync_q && ((^shift_q) ^ parity_q)) begin
                        commit_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_q != StIdle) begin
            if (fe) begin
                tmo_d = '0;
            end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
                state_d = StIdle;
                err_d   = 1'b1;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TmoW'(1);
            end
        end
    end

    // Frame FSM state register; commit/error become one-cycle pulses.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tmo_q     <= '0;
            commit_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tmo_q     <= tmo_d;
            commit_q  <= commit_d;
            err_q     <= err_d;
        end
    end

    assign rd_key    = READ_STROBE && (PORT_ID == KEY_PORT);
    assign rd_status = READ_STROBE && (PORT_ID == STATUS_PORT);

    // Read port and key/status register updates; set events win over read clears.
    always_comb begin
        key_d       = key_q;
        prev_d      = prev_q;
        in_port_d   = in_port_q;
        key_ready_d = key_ready_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;

        if (READ_STROBE) begin
            if (rd_key) begin
                in_port_d = key_q;
            end else if (rd_status) begin
                in_port_d = {5'b0, overrun_q, frame_err_q, key_ready_q};
            end else begin
                in_port_d = 8'h00;
            end
        end

        if (rd_key) begin
            key_ready_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (rd_status) begin
            frame_err_d = 1'b0;
        end

        if (commit_q) begin
            prev_d = key_q;
            key_d  = shift_q;
            // A read in the same cycle consumed the old key, so no overrun.
            if (key_ready_q && !rd_key) begin
                overrun_d = 1'b1;
            end
            key_ready_d = 1'b1;
        end
        if (err_q) begin
            frame_err_d = 1'b1;
        end
    end

    // Host-visible register bank.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            key_q       <= 8'h00;
            prev_q      <= 8'h00;
            in_port_q   <= 8'h00;
            key_ready_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            key_q       <= key_d;
            prev_q      <= prev_d;
            in_port_q   <= in_port_d;
            key_ready_q <= key_ready_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign IN_PORT             = in_port_q;
    assign TecladoREG          = key_q;
    assign TecladoREG_ANTERIOR = prev_q;
    assign KEY_READY           = key_ready_q;
    assign FRAME_ERR           = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: directed scenarios plus random frames and reads,
// checked against a frame-level model of the receiver's registers.
module tb_ps2_keyboard_rx;

    localparam int unsigned FILT = 8;
    localparam int unsigned TMO  = 300;
    localparam logic [7:0]  KEYP = 8'h0F;
    localparam logic [7:0]  STSP = 8'h10;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       read_strobe = 1'b0;
    logic [7:0] port_id = 8'h00;
    logic [7:0] in_port;
    logic [7:0] key;
    logic [7:0] key_prev;
    logic       key_ready;
    logic       frame_err;

    int checks = 0;
    int failures = 0;
    int half = 20;

    // Reference model state
    logic [7:0] m_key, m_prev, m_in;
    logic       m_ready, m_ovr, m_err;

    ps2_keyboard_rx #(
        .FILTER_LEN (FILT),
        .TIMEOUT_CYC(TMO),
        .KEY_PORT   (KEYP),
        .STATUS_PORT(STSP)
    ) dut (
        .CLK                (CLK),
        .RST                (RST),
        .PS2_CLK            (ps2_clk),
        .PS2_DATA           (ps2_data),
        .READ_STROBE        (read_strobe),
        .PORT_ID            (port_id),
        .IN_PORT            (in_port),
        .TecladoREG         (key),
        .TecladoREG_ANTERIOR(key_prev),
        .KEY_READY          (key_ready),
        .FRAME_ERR          (frame_err)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_key = 8'h00; m_prev = 8'h00; m_in = 8'h00;
        m_ready = 1'b0; m_ovr = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_read(input logic [7:0] p);
        if (p == KEYP) begin
            m_in = m_key; m_ready = 1'b0; m_ovr = 1'b0;
        end else if (p == STSP) begin
            m_in = {5'b0, m_ovr, m_err, m_ready}; m_err = 1'b0;
        end else begin
            m_in = 8'h00;
        end
    endtask

    task automatic model_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        if (!bad_par && !bad_stop) begin
            m_ovr   = m_ovr | m_ready;
            m_prev  = m_key;
            m_key   = d;
            m_ready = 1'b1;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic check_state(input string tag);
        check_val({tag, ".key"}, {24'b0, key}, {24'b0, m_key});
        check_val({tag, ".prev"}, {24'b0, key_prev}, {24'b0, m_prev});
        check_val({tag, ".ready"}, {31'b0, key_ready}, {31'b0, m_ready});
        check_val({tag, ".err"}, {31'b0, frame_err}, {31'b0, m_err});
    endtask

    // One PS/2 bit; optionally pulses a KEY_PORT read in the commit cycle of this FE.
    task automatic ps2_bit(input logic b, input bit strobe_commit);
        @(negedge CLK);
        ps2_data = b;
        repeat (half) @(negedge CLK);
        ps2_clk = 1'b0;
        if (strobe_commit) begin
            // 2 sync + FILTER_LEN filter cycles to FE, one more to commit.
            repeat (11) @(posedge CLK);
            @(negedge CLK);
            read_strobe = 1'b1;
            port_id = KEYP;
            @(negedge CLK);
            read_strobe = 1'b0;
            port_id = 8'h00;
        end
        repeat (half) @(negedge CLK);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input bit strobe_commit);
        logic par;
        par = (~^d) ^ bad_par;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0);
        ps2_bit(par, 1'b0);
        ps2_bit(~bad_stop, strobe_commit);
        @(negedge CLK);
        ps2_data = 1'b1;
        repeat (20) @(negedge CLK);
        if (strobe_commit) model_read(KEYP);
        model_frame(d, bad_par, bad_stop);
    endtask

    task automatic read_port(input logic [7:0] p, input string tag);
        @(negedge CLK);
        read_strobe = 1'b1;
        port_id = p;
        @(negedge CLK);
        read_strobe = 1'b0;
        port_id = 8'h00;
        model_read(p);
        check_val({tag, ".in_port"}, {24'b0, in_port}, {24'b0, m_in});
        check_state(tag);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] p;
        bit         bp, bs;

        model_reset();
        repeat (4) @(negedge CLK);
        check_val("reset.in_port", {24'b0, in_port}, 32'h0);
        check_state("reset");
        RST = 1'b1;
        repeat (5) @(negedge CLK);

        // Reset asserted mid-frame discards the partial frame.
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b1, 1'b0);
        @(negedge CLK);
        ps2_clk = 1'b0;
        repeat (12) @(negedge CLK);
        RST = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        model_reset();
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (20) @(negedge CLK);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check_state("rst_then_1c");

        // Break sequence with no reads in between -> overrun.
        send_frame(8'h75, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0, 1'b0);
        check_state("break");
        read_port(STSP, "break_status");
        read_port(KEYP, "break_key");

        // Parity error leaves the key untouched; status read reports and clears it.
        send_frame(8'h72, 1'b1, 1'b0, 1'b0);
        check_state("parity_err");
        read_port(STSP, "parity_status");

        // Timeout after start + 3 data bits.
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        repeat (TMO + 10) @(negedge CLK);
        m_err = 1'b1;
        check_state("timeout");
        read_port(STSP, "timeout_status");
        send_frame(8'h6B, 1'b0, 1'b0, 1'b0);
        check_state("after_timeout");

        // KEY_PORT read landing in the commit cycle of the next frame.
        send_frame(8'h74, 1'b0, 1'b0, 1'b1);
        check_val("collide.in_port", {24'b0, in_port}, {24'b0, m_in});
        check_state("collide");
        read_port(STSP, "collide_status");

        // Short low glitch on PS2_CLK in idle must not start a frame.
        @(negedge CLK);
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        repeat (5) @(negedge CLK);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (20) @(negedge CLK);
        check_state("glitch");
        send_frame(8'h29, 1'b0, 1'b0, 1'b0);
        check_state("after_glitch");
        read_port(8'h33, "unknown_port");
        repeat (3) @(negedge CLK);
        check_val("in_port_hold", {24'b0, in_port}, {24'b0, m_in});

        // Random frames, errors and reads.
        for (int n = 0; n < 25; n++) begin
            half = $urandom_range(12, 30);
            d  = 8'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 7) == 0);
            send_frame(d, bp, bs, 1'b0);
            check_state("rand_frame");
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 2))
                    0: p = KEYP;
                    1: p = STSP;
                    default: p = 8'($urandom);
                endcase
                read_port(p, "rand_read");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
